// File: rtl/disp_timing_pkg.sv
// disp_timing_pkg: timing sets for the supported panel modes and the RGB888
// colour constants shared between the timing controller and the pattern sources.
package disp_timing_pkg;

  // Scan counters and active-area addresses are 12 bits wide throughout.
  localparam int unsigned CNT_W = 12;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [23:0]      rgb_t;   // {R[23:16], G[15:8], B[7:0]}

  // One complete set of horizontal (pixels) and vertical (lines) timings.
  typedef struct packed {
    int unsigned h_sync;
    int unsigned h_back;
    int unsigned h_active;
    int unsigned h_front;
    int unsigned v_sync;
    int unsigned v_back;
    int unsigned v_active;
    int unsigned v_front;
  } timing_t;

  typedef enum logic [1:0] {
    MODE_640X480,
    MODE_800X480,
    MODE_1024X600
  } mode_e;

  localparam timing_t TIMING_640X480 = '{
    h_sync: 96, h_back: 48, h_active: 640, h_front: 16,
    v_sync: 2,  v_back: 33, v_active: 480, v_front: 10
  };

  localparam timing_t TIMING_800X480 = '{
    h_sync: 48, h_back: 88, h_active: 800, h_front: 40,
    v_sync: 3,  v_back: 32, v_active: 480, v_front: 13
  };

  localparam timing_t TIMING_1024X600 = '{
    h_sync: 20, h_back: 140, h_active: 1024, h_front: 160,
    v_sync: 3,  v_back: 20,  v_active: 600,  v_front: 12
  };

  // Colour index: bit 2 = red, bit 1 = green, bit 0 = blue, each fully on or off.
  typedef enum logic [2:0] {
    C_BLACK, C_BLUE, C_GREEN, C_CYAN, C_RED, C_MAGENTA, C_YELLOW, C_WHITE
  } colour_e;

  localparam rgb_t RGB_BLACK   = 24'h000000;
  localparam rgb_t RGB_BLUE    = 24'h0000FF;
  localparam rgb_t RGB_GREEN   = 24'h00FF00;
  localparam rgb_t RGB_CYAN    = 24'h00FFFF;
  localparam rgb_t RGB_RED     = 24'hFF0000;
  localparam rgb_t RGB_MAGENTA = 24'hFF00FF;
  localparam rgb_t RGB_YELLOW  = 24'hFFFF00;
  localparam rgb_t RGB_WHITE   = 24'hFFFFFF;

  function automatic timing_t timing_of(mode_e mode);
    case (mode)
      MODE_800X480:  return TIMING_800X480;
      MODE_1024X600: return TIMING_1024X600;
      default:       return TIMING_640X480;
    endcase
  endfunction

  function automatic int unsigned h_total(timing_t t);
    return t.h_sync + t.h_back + t.h_active + t.h_front;
  endfunction

  function automatic int unsigned v_total(timing_t t);
    return t.v_sync + t.v_back + t.v_active + t.v_front;
  endfunction

  // Expands a colour index into its RGB888 value (each channel 00 or FF).
  function automatic rgb_t colour_rgb(colour_e c);
    logic [2:0] b;
    b = c;
    return {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
  endfunction

endpackage

// File: rtl/disp_timing_ctrl_if.sv
// disp_timing_ctrl_if: pixel request bus towards the frame-data source plus
// the registered panel bus. The timing controller is the master; the
// source/panel side is the slave.
interface disp_timing_ctrl_if;
  import disp_timing_pkg::*;

  rgb_t disp_data;       // pixel returned for the current request
  logic disp_data_req;   // source must present disp_data this cycle
  cnt_t disp_h_addr;     // active-area column
  cnt_t disp_v_addr;     // active-area row
  logic disp_hs;
  logic disp_vs;
  logic disp_de;
  rgb_t disp_rgb;
  logic frame_start;

  modport master (
    input  disp_data,
    output disp_data_req, disp_h_addr, disp_v_addr,
    output disp_hs, disp_vs, disp_de, disp_rgb, frame_start
  );

  modport slave (
    output disp_data,
    input  disp_data_req, disp_h_addr, disp_v_addr,
    input  disp_hs, disp_vs, disp_de, disp_rgb, frame_start
  );

endinterface

// File: rtl/disp_wrap_cnt.sv
// disp_wrap_cnt: free-running counter with enable that returns to zero after
// reaching a terminal value. wrap flags the enabled cycle on which the
// counter moves from term back to 0, so it can enable a cascaded counter.
module disp_wrap_cnt #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = en && (cnt == term);

  // Count up while enabled, restarting at zero after the terminal value.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking assignments here would make results depend on
  // process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/disp_timing_ctrl.sv
// disp_timing_ctrl: display timing generator and pixel output stage.
// Horizontal/vertical scan counters decode into a pixel request issued one
// clock ahead of the panel pixel; the returned disp_data is registered onto
// the panel bus together with DE, HS and VS so all four stay aligned.
//
// Build option: define DISP_BORDER_EN to force the outermost row/column of
// the active area to white (panel alignment aid). Undefined, active pixels
// pass disp_data through unchanged.
module disp_timing_ctrl
  import disp_timing_pkg::*;
#(
  parameter int unsigned H_SYNC   = TIMING_640X480.h_sync,
  parameter int unsigned H_BACK   = TIMING_640X480.h_back,
  parameter int unsigned H_ACTIVE = TIMING_640X480.h_active,
  parameter int unsigned H_FRONT  = TIMING_640X480.h_front,
  parameter int unsigned V_SYNC   = TIMING_640X480.v_sync,
  parameter int unsigned V_BACK   = TIMING_640X480.v_back,
  parameter int unsigned V_ACTIVE = TIMING_640X480.v_active,
  parameter int unsigned V_FRONT  = TIMING_640X480.v_front,
  parameter bit          SYNC_POL = 1'b0   // active level of HS/VS
) (
  input  logic               clk,
  input  logic               reset_n,
  disp_timing_ctrl_if.master bus
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam cnt_t H_LAST     = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST     = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_SYNC_END = cnt_t'(H_SYNC);
  localparam cnt_t V_SYNC_END = cnt_t'(V_SYNC);

  // The horizontal request window opens one pixel before the active region
  // so the registered pixel lands exactly on the first active column.
  localparam cnt_t H_REQ_LO = cnt_t'(H_SYNC + H_BACK - 1);
  localparam cnt_t H_REQ_HI = cnt_t'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam cnt_t V_REQ_LO = cnt_t'(V_SYNC + V_BACK);
  localparam cnt_t V_REQ_HI = cnt_t'(V_SYNC + V_BACK + V_ACTIVE);

  // ---------------------------------------------------------------------------
  // Scan counters: h runs every clock, v steps on each h wrap.
  // ---------------------------------------------------------------------------
  cnt_t h_cnt;
  cnt_t v_cnt;
  logic h_wrap;
  logic v_wrap;

  disp_wrap_cnt #(.W(CNT_W)) u_h_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (1'b1),
    .term    (H_LAST),
    .cnt     (h_cnt),
    .wrap    (h_wrap)
  );

  disp_wrap_cnt #(.W(CNT_W)) u_v_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (h_wrap),
    .term    (V_LAST),
    .cnt     (v_cnt),
    .wrap    (v_wrap)
  );

  // ---------------------------------------------------------------------------
  // Combinational decode: pixel request and active-area address.
  // ---------------------------------------------------------------------------
  logic h_req;
  logic v_req;
  logic req_c;
  cnt_t h_addr_c;
  cnt_t v_addr_c;
  rgb_t pix_c;

  assign h_req    = (h_cnt >= H_REQ_LO) && (h_cnt < H_REQ_HI);
  assign v_req    = (v_cnt >= V_REQ_LO) && (v_cnt < V_REQ_HI);
  assign req_c    = h_req && v_req;
  assign h_addr_c = req_c ? (h_cnt - H_REQ_LO) : '0;
  assign v_addr_c = req_c ? (v_cnt - V_REQ_LO) : '0;

`ifdef DISP_BORDER_EN
  localparam cnt_t H_ADDR_LAST = cnt_t'(H_ACTIVE - 1);
  localparam cnt_t V_ADDR_LAST = cnt_t'(V_ACTIVE - 1);

  logic border_c;

  // Outside the request window the addresses read 0, so border_c is also
  // high there; the req_c mux at the output register masks that case.
  assign border_c = (h_addr_c == '0) || (h_addr_c == H_ADDR_LAST) ||
                    (v_addr_c == '0) || (v_addr_c == V_ADDR_LAST);
  assign pix_c    = border_c ? RGB_WHITE : bus.disp_data;
`else
  assign pix_c    = bus.disp_data;
`endif

  assign bus.disp_data_req = req_c;
  assign bus.disp_h_addr   = h_addr_c;
  assign bus.disp_v_addr   = v_addr_c;

  // ---------------------------------------------------------------------------
  // Frame origin tracking.
  // ---------------------------------------------------------------------------
  // The counters sit at (0,0) only straight out of reset or on the cycle
  // after a frame wrap, so one flop replaces a full-width compare of both.
  logic at_origin;

  // Flag the cycle whose counters are (0,0).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      at_origin <= 1'b1;
    end else begin
      at_origin <= v_wrap;
    end
  end

  // ---------------------------------------------------------------------------
  // Panel bus register: pixel, DE, syncs and frame pulse share one stage.
  // ---------------------------------------------------------------------------
  // Register the decoded timing and the returned pixel onto the panel bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.disp_de     <= 1'b0;
      bus.disp_rgb    <= '0;
      bus.disp_hs     <= ~SYNC_POL;
      bus.disp_vs     <= ~SYNC_POL;
      bus.frame_start <= 1'b0;
    end else begin
      bus.disp_de     <= req_c;
      bus.disp_rgb    <= req_c ? pix_c : '0;
      bus.disp_hs     <= (h_cnt < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
      bus.disp_vs     <= (v_cnt < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
      bus.frame_start <= at_origin;
    end
  end

endmodule

// File: tb/tb_disp_timing_ctrl.sv
// tb_disp_timing_ctrl: two controllers share one clock. dut_a runs the
// default 640x480 timing with active-low syncs and a constant green source;
// dut_b runs a tiny raster with active-high syncs and random pixel data so
// whole frames, frame_start spacing and a mid-line reset fit in a short run.
// Expected values come from absolute time since reset release:
// h = t mod H_TOTAL, v = (t / H_TOTAL) mod V_TOTAL.
module tb_disp_timing_ctrl;
  import disp_timing_pkg::*;

  localparam int B_HS = 4, B_HB = 3, B_HA = 8, B_HF = 2;
  localparam int B_VS = 2, B_VB = 2, B_VA = 5, B_VF = 1;

  typedef struct {
    int hs, hb, ha, hf, vs, vb, va, vf;
    bit pol;
  } geom_t;

  // Reference decode for one absolute time step.
  typedef struct {
    bit req;
    int hx;
    int vy;
    bit hs;
    bit vs;
    bit fs;
  } dec_t;

  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;

  always #5 clk = ~clk;

  disp_timing_ctrl_if bus_a ();
  disp_timing_ctrl_if bus_b ();

  disp_timing_ctrl u_dut_a (
    .clk     (clk),
    .reset_n (rst_a_n),
    .bus     (bus_a)
  );

  disp_timing_ctrl #(
    .H_SYNC(B_HS), .H_BACK(B_HB), .H_ACTIVE(B_HA), .H_FRONT(B_HF),
    .V_SYNC(B_VS), .V_BACK(B_VB), .V_ACTIVE(B_VA), .V_FRONT(B_VF),
    .SYNC_POL(1'b1)
  ) u_dut_b (
    .clk     (clk),
    .reset_n (rst_b_n),
    .bus     (bus_b)
  );

  int          errors = 0;
  int          checks = 0;
  geom_t       geo [2];
  int          t [2];
  bit          live [2];
  dec_t        prev [2];
  logic [23:0] prev_data [2];

  // Sync-width and frame-period measurements.
  int a_hs_act = 0;
  int a_vs_act = 0;
  int b_hs_act = 0;
  int b_vs_act = 0;
  bit b_meas   = 1'b0;
  int b_fs_t [$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic dec_t decode(geom_t g, int tt);
    dec_t d;
    int ht, vt, h, v;
    ht    = g.hs + g.hb + g.ha + g.hf;
    vt    = g.vs + g.vb + g.va + g.vf;
    h     = tt % ht;
    v     = (tt / ht) % vt;
    d.req = (h >= g.hs + g.hb - 1) && (h < g.hs + g.hb + g.ha - 1) &&
            (v >= g.vs + g.vb) && (v < g.vs + g.vb + g.va);
    d.hx  = d.req ? h - (g.hs + g.hb - 1) : 0;
    d.vy  = d.req ? v - (g.vs + g.vb) : 0;
    d.hs  = (h < g.hs) ? g.pol : !g.pol;
    d.vs  = (v < g.vs) ? g.pol : !g.pol;
    d.fs  = (h == 0) && (v == 0);
    return d;
  endfunction

  function automatic logic [23:0] pixel(geom_t g, dec_t d, logic [23:0] data);
    if (!d.req) return 24'h0;
`ifdef DISP_BORDER_EN
    if (d.hx == 0 || d.hx == g.ha - 1 || d.vy == 0 || d.vy == g.va - 1)
      return 24'hFFFFFF;
`endif
    return data;
  endfunction

  // Compare every output of one DUT against the reference.
  task automatic check_dut(int i, string nm);
    dec_t        c;
    logic        req, de, hs, vs, fs;
    logic [11:0] hx, vy;
    logic [23:0] rgb;
    if (i == 0) begin
      req = bus_a.disp_data_req; hx = bus_a.disp_h_addr; vy = bus_a.disp_v_addr;
      de  = bus_a.disp_de; rgb = bus_a.disp_rgb; hs = bus_a.disp_hs;
      vs  = bus_a.disp_vs; fs  = bus_a.frame_start;
    end else begin
      req = bus_b.disp_data_req; hx = bus_b.disp_h_addr; vy = bus_b.disp_v_addr;
      de  = bus_b.disp_de; rgb = bus_b.disp_rgb; hs = bus_b.disp_hs;
      vs  = bus_b.disp_vs; fs  = bus_b.frame_start;
    end
    c = decode(geo[i], t[i]);
    check({nm, ".req"},    req, c.req);
    check({nm, ".h_addr"}, hx,  c.hx);
    check({nm, ".v_addr"}, vy,  c.vy);
    check({nm, ".de"},     de,  live[i] ? prev[i].req : 1'b0);
    check({nm, ".rgb"},    rgb, live[i] ? pixel(geo[i], prev[i], prev_data[i]) : 24'h0);
    check({nm, ".hs"},     hs,  live[i] ? prev[i].hs : !geo[i].pol);
    check({nm, ".vs"},     vs,  live[i] ? prev[i].vs : !geo[i].pol);
    check({nm, ".fs"},     fs,  live[i] ? prev[i].fs : 1'b0);
  endtask

  // One pixel clock: advance the reference at the edge, check both DUTs on
  // the falling edge, then present fresh source data.
  task automatic tick();
    @(posedge clk);
    if (rst_a_n) begin
      prev[0] = decode(geo[0], t[0]); prev_data[0] = bus_a.disp_data; live[0] = 1'b1; t[0]++;
    end
    if (rst_b_n) begin
      prev[1] = decode(geo[1], t[1]); prev_data[1] = bus_b.disp_data; live[1] = 1'b1; t[1]++;
    end
    @(negedge clk);
    check_dut(0, "A");
    check_dut(1, "B");
    if (rst_a_n && t[0] >= 1 && t[0] <= 1600 && bus_a.disp_hs == 1'b0) a_hs_act++;
    if (rst_a_n && t[0] >= 1 && t[0] <= 28000 && bus_a.disp_vs == 1'b0) a_vs_act++;
    if (b_meas && rst_b_n && t[1] >= 1 && t[1] <= 170) begin
      if (bus_b.disp_hs == 1'b1) b_hs_act++;
      if (bus_b.disp_vs == 1'b1) b_vs_act++;
    end
    if (b_meas && rst_b_n && bus_b.frame_start) b_fs_t.push_back(t[1]);
    bus_a.disp_data = 24'h00FF00;
    bus_b.disp_data = 24'($urandom());
  endtask

  task automatic set_rst(int i, logic v);
    if (i == 0) rst_a_n = v;
    else        rst_b_n = v;
    if (!v) begin
      t[i]    = 0;
      live[i] = 1'b0;
    end
  endtask

  // Wait (bounded) for dut_b to request pixel (x,y) and check what it shows.
  task automatic pix_b(string tag, int x, int y);
    int          n;
    logic [23:0] d, e;
    n = 0;
    while (!(bus_b.disp_data_req && bus_b.disp_h_addr == 12'(x) &&
             bus_b.disp_v_addr == 12'(y)) && n < 400) begin
      tick();
      n++;
    end
    check({tag, ".found"}, n < 400, 1'b1);
    d = bus_b.disp_data;
`ifdef DISP_BORDER_EN
    e = (x == 0 || x == B_HA - 1 || y == 0 || y == B_VA - 1) ? 24'hFFFFFF : d;
`else
    e = d;
`endif
    tick();
    check({tag, ".rgb"}, bus_b.disp_rgb, e);
  endtask

  initial begin
    int          n;
    int          cnt;
    logic [11:0] last_h;

    geo[0] = '{hs: 96, hb: 48, ha: 640, hf: 16, vs: 2, vb: 33, va: 480, vf: 10, pol: 1'b0};
    geo[1] = '{hs: B_HS, hb: B_HB, ha: B_HA, hf: B_HF,
               vs: B_VS, vb: B_VB, va: B_VA, vf: B_VF, pol: 1'b1};
    for (int i = 0; i < 2; i++) begin
      t[i] = 0; live[i] = 1'b0; prev_data[i] = '0;
      prev[i] = '{req: 1'b0, hx: 0, vy: 0, hs: 1'b0, vs: 1'b0, fs: 1'b0};
    end
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    bus_a.disp_data = 24'h00FF00;
    bus_b.disp_data = 24'($urandom());

    // Reset state of both controllers.
    repeat (3) tick();

    // dut_a: first request of the frame lands at h=143, v=35.
    set_rst(0, 1'b1);
    n = 0;
    while (!bus_a.disp_data_req && n < 30000) begin
      tick();
      n++;
    end
    check("A.first_req_time", n, 35 * 800 + 143);
    check("A.first_req_h", bus_a.disp_h_addr, 0);
    check("A.first_req_v", bus_a.disp_v_addr, 0);
    tick();
    check("A.first_de", bus_a.disp_de, 1'b1);
    check("A.first_rgb", bus_a.disp_rgb, 24'h00FF00);

    // Walk the rest of active line 0.
    last_h = '0;
    cnt = 1;
    while (bus_a.disp_data_req && cnt < 1000) begin
      last_h = bus_a.disp_h_addr;
      cnt++;
      tick();
    end
    check("A.last_req_h", last_h, 639);
    check("A.req_per_line", cnt, 640);
    check("A.tail_de", bus_a.disp_de, 1'b1);
    check("A.tail_rgb", bus_a.disp_rgb, 24'h00FF00);
    tick();
    check("A.de_after_line", bus_a.disp_de, 1'b0);
    check("A.rgb_after_line", bus_a.disp_rgb, 24'h0);
    check("A.hs_low_2_lines", a_hs_act, 2 * 96);
    check("A.vs_low_clocks", a_vs_act, 1600);

    // dut_b: several complete frames with active-high syncs.
    set_rst(1, 1'b1);
    b_meas = 1'b1;
    repeat (4 * 170) tick();
    b_meas = 1'b0;
    check("B.hs_high_per_frame", b_hs_act, 10 * B_HS);
    check("B.vs_high_per_frame", b_vs_act, B_VS * 17);
    check("B.fs_count", b_fs_t.size(), 4);
    if (b_fs_t.size() >= 2) begin
      check("B.fs_first", b_fs_t[0], 1);
      check("B.fs_period", b_fs_t[1] - b_fs_t[0], 170);
    end else begin
      check("B.fs_seen", b_fs_t.size(), 4);
    end

    // Reset in the middle of an active line.
    n = 0;
    while (!(bus_b.disp_data_req && bus_b.disp_h_addr == 12'd3) && n < 400) begin
      tick();
      n++;
    end
    check("B.mid_line_found", n < 400, 1'b1);
    set_rst(1, 1'b0);
    #1;
    check_dut(1, "B.async_rst");
    repeat (3) tick();
    set_rst(1, 1'b1);
    tick();
    check("B.fs_after_release", bus_b.frame_start, 1'b1);
    n = 1;
    while (!bus_b.disp_data_req && n < 400) begin
      tick();
      n++;
    end
    check("B.restart_req_time", n, (B_VS + B_VB) * 17 + (B_HS + B_HB - 1));
    check("B.restart_h", bus_b.disp_h_addr, 0);
    check("B.restart_v", bus_b.disp_v_addr, 0);

    // Border and interior pixels of the small raster.
    pix_b("B.pix_0_2", 0, 2);
    pix_b("B.pix_7_2", B_HA - 1, 2);
    pix_b("B.pix_2_4", 2, B_VA - 1);
    pix_b("B.pix_2_0", 2, 0);
    pix_b("B.pix_2_2", 2, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
